yarp_data_mem_resp: RTL and testbench
=====================================

YARP_DATA_MEM_RESP -- requirements
Module: yarp_data_mem_resp

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_2000, SHALL give the byte address of RAM word 0.
REQ-002 Parameter MEM_DEPTH, default 1024, SHALL give the RAM size in 32-bit words.
REQ-003 Parameter MMIO_BASE, default 32'hFFFF_0000, SHALL give the TOHOST address; the CYCLE address SHALL be MMIO_BASE+4.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 data_mem_req_i  in  1  SHALL be the access request from the core.
REQ-007 data_mem_addr_i  in  32  SHALL be the byte address.
REQ-008 data_mem_byte_en_i  in  2  SHALL be the access size: 00 byte, 01 half, 11 word, 10 reserved.
REQ-009 data_mem_wr_i  in  1  SHALL mean write when 1 and read when 0.
REQ-010 data_mem_wr_data_i  in  32  SHALL carry LSB-aligned store data.
REQ-011 data_mem_rd_data_o  out  32  SHALL carry the full aligned word; the core does lane select and extension.
REQ-012 tohost_valid_o  out  1  SHALL be a sticky flag meaning TOHOST has been written.
REQ-013 tohost_data_o  out  32  SHALL hold the last value written to TOHOST.
REQ-014 err_o  out  1  SHALL be a sticky error flag.
REQ-015 err_addr_o  out  32  SHALL hold the address of the first error.
REQ-016 stat_rd_cnt_o  out  16  SHALL count successful reads (see Configuration).
REQ-017 stat_wr_cnt_o  out  16  SHALL count successful writes (see Configuration).

Function
REQ-018 Decode: RAM SHALL span BASE_ADDR to BASE_ADDR+4*MEM_DEPTH-1; TOHOST and CYCLE are the MMIO words; every other address is unmapped.
REQ-019 Read SHALL be combinational, zero-latency: req=1, wr=0 gives RAM word index (addr-BASE_ADDR)>>2, the TOHOST value or the CYCLE value.
REQ-020 rd_data_o SHALL be 0 when req=0, when wr=1, or when the address is unmapped.
REQ-021 Write SHALL commit at the rising edge when req=1 and wr=1; byte writes lane addr[1:0] with data[7:0], half writes lane addr[1] with data[15:0], word writes all lanes.
REQ-022 Read-during-write to the same word SHALL return the pre-edge contents.
REQ-023 Error conditions are a misaligned access (half with addr[0]=1, word with addr[1:0]!=0), byte_en=10, any unmapped access, and a non-word TOHOST write.
REQ-024 An erroring write SHALL NOT modify any state except the error registers; an erroring read SHALL return 0.
REQ-025 On the first error, err_o<=1 and err_addr_o<=addr at the next edge; later errors SHALL leave err_addr_o unchanged.
REQ-026 A word write to TOHOST SHALL set tohost_data_o<=wr_data and tohost_valid_o<=1 at the edge; a rewrite SHALL update the data and keep valid at 1.
REQ-027 CYCLE SHALL be 0 after reset, increment by 1 every cycle, and wrap from FFFF_FFFF to 0; writes to CYCLE SHALL be ignored without error.
REQ-028 A read of CYCLE SHALL return the pre-increment value of that cycle.

Reset
REQ-029 With reset=1 at an edge, tohost_valid_o, tohost_data_o, err_o, err_addr_o, CYCLE and both stat counters SHALL become 0.
REQ-030 A write presented in the same cycle as reset SHALL be dropped.
REQ-031 RAM contents SHALL NOT be reset.

Configuration
REQ-032 With macro YARP_MEM_STATS_EN defined, the stat counters SHALL increment per successful read or write request-cycle and saturate at 16'hFFFF.
REQ-033 With YARP_MEM_STATS_EN undefined, no counter registers SHALL exist and both stat outputs SHALL be tied to 0.

Verification
REQ-034 Word write 32'hA5A5_1234 to 0x2000, then read 0x2000 -> rd_data_o=32'hA5A5_1234 in the same cycle as the read req, err_o=0.
REQ-035 Write word 0 to 0x2004, then byte 0xEF to 0x2006, then half 0xBEEF to 0x2004 -> read 0x2004 returns 32'h00EF_BEEF.
REQ-036 Word write to 0x2002 -> no RAM change, err_o=1, err_addr_o=0x2002; a later read of 0x9000 leaves err_addr_o=0x2002 and returns 0.
REQ-037 Word write 32'h1 to 0xFFFF_0000 -> tohost_valid_o=1, tohost_data_o=1 next cycle; a byte write to 0xFFFF_0000 sets err_o and leaves tohost_data_o=1.
REQ-038 Release reset, wait 10 cycles, read 0xFFFF_0004 -> 32'd10; assert reset mid-run -> CYCLE and err_o return to 0 while RAM keeps its data.
REQ-039 With YARP_MEM_STATS_EN defined, 70000 back-to-back reads -> stat_rd_cnt_o=16'hFFFF; undefined -> stat_rd_cnt_o stays 0.

Source files
------------

// File: rtl/yarp_data_mem_resp.sv
// yarp_data_mem_resp: data memory responder for the YARP core.
// Holds a word-organised RAM window at BASE_ADDR plus two MMIO words:
// TOHOST at MMIO_BASE and a free-running CYCLE counter at MMIO_BASE+4.
// Reads are combinational; writes, error capture and MMIO updates happen
// on the rising clock edge. Reset is synchronous and active-high.
// Optional feature: define YARP_MEM_STATS_EN to build saturating
// read/write success counters; without it the stat outputs are tied to 0.
module yarp_data_mem_resp #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_mem_wr_data_i,
    output logic [31:0] data_mem_rd_data_o,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    output logic [15:0] stat_rd_cnt_o,
    output logic [15:0] stat_wr_cnt_o
);

    localparam int          IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] RAM_BYTES  = 33'(MEM_DEPTH) << 2;
    localparam logic [31:0] CYCLE_ADDR = MMIO_BASE + 32'd4;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_TOHOST,
        TGT_CYCLE
    } target_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_RSVD = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    logic [31:0] mem [MEM_DEPTH];

    size_e            size;
    target_e          target;
    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic             misaligned;
    logic             access_err;
    logic             rd_en;
    logic             wr_en;
    logic [3:0]       lane_mask;
    logic [31:0]      lane_data;

    logic             tohost_valid_q;
    logic [31:0]      tohost_data_q;
    logic             err_q;
    logic [31:0]      err_addr_q;
    logic [31:0]      cycle_q;

    assign size     = size_e'(data_mem_byte_en_i);
    assign offset   = data_mem_addr_i - BASE_ADDR;
    assign word_idx = offset[IDX_W+1:2];

    // Address decode: RAM window first, then the two MMIO words (any byte of each word).
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        target = TGT_NONE;
        if (data_mem_addr_i >= BASE_ADDR && {1'b0, offset} < RAM_BYTES) begin
            target = TGT_RAM;
        end else if (data_mem_addr_i[31:2] == MMIO_BASE[31:2]) begin
            target = TGT_TOHOST;
        end else if (data_mem_addr_i[31:2] == CYCLE_ADDR[31:2]) begin
            target = TGT_CYCLE;
        end
    end

    // Error classification and the qualified read/write strobes.
    always_comb begin
        misaligned = ((size == SZ_HALF) && data_mem_addr_i[0]) ||
                     ((size == SZ_WORD) && (data_mem_addr_i[1:0] != 2'b00));
        access_err = data_mem_req_i &&
                     (misaligned || (size == SZ_RSVD) || (target == TGT_NONE) ||
                      (data_mem_wr_i && (target == TGT_TOHOST) && (size != SZ_WORD)));
        rd_en      = data_mem_req_i && !data_mem_wr_i && !access_err;
        // A write in a reset cycle is dropped, including the RAM which has no reset.
        wr_en      = data_mem_req_i && data_mem_wr_i && !access_err && !reset;
    end

    // Store lane selection: replicate LSB-aligned data and enable the addressed lanes.
    always_comb begin
        lane_mask = 4'b1111;
        lane_data = data_mem_wr_data_i;
        case (size)
            SZ_BYTE: begin
                lane_mask = 4'b0001 << data_mem_addr_i[1:0];
                lane_data = {4{data_mem_wr_data_i[7:0]}};
            end
            SZ_HALF: begin
                lane_mask = data_mem_addr_i[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{data_mem_wr_data_i[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = data_mem_wr_data_i;
            end
        endcase
    end

    // Zero-latency read mux; returns pre-edge contents, zero when idle, writing or erroring.
    always_comb begin
        data_mem_rd_data_o = '0;
        if (rd_en) begin
            case (target)
                TGT_RAM:    data_mem_rd_data_o = mem[word_idx];
                TGT_TOHOST: data_mem_rd_data_o = tohost_data_q;
                TGT_CYCLE:  data_mem_rd_data_o = cycle_q;
                default:    data_mem_rd_data_o = '0;
            endcase
        end
    end

    // RAM byte-lane write.
    // NOTE: the RAM array has no reset branch; clearing it would turn the storage into flops and its contents must survive reset anyway.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && (target == TGT_RAM) && lane_mask[i]) begin
                mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    // MMIO state, sticky error capture and the free-running cycle counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= '0;
            err_q          <= 1'b0;
            err_addr_q     <= '0;
            cycle_q        <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (wr_en && (target == TGT_TOHOST)) begin
                tohost_valid_q <= 1'b1;
                tohost_data_q  <= data_mem_wr_data_i;
            end
            if (access_err && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= data_mem_addr_i;
            end
        end
    end

    assign tohost_valid_o = tohost_valid_q;
    assign tohost_data_o  = tohost_data_q;
    assign err_o          = err_q;
    assign err_addr_o     = err_addr_q;

`ifdef YARP_MEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Saturating counters of successful read and write request-cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_en && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (wr_en && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign stat_rd_cnt_o = rd_cnt_q;
    assign stat_wr_cnt_o = wr_cnt_q;
`else
    assign stat_rd_cnt_o = '0;
    assign stat_wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_yarp_data_mem_resp.sv
// Self-checking bench for yarp_data_mem_resp (default parameters).
// Read expectations go into a scoreboard queue when the read is driven and
// are popped by a monitor that samples the combinational read data two
// time units after the driving (falling) edge.
module tb_yarp_data_mem_resp;

    localparam logic [31:0] TOHOST = 32'hFFFF_0000;
    localparam logic [31:0] CYCLE  = 32'hFFFF_0004;

    logic        clk;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic [1:0]  byte_en;
    logic        wr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        err;
    logic [31:0] err_addr;
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    yarp_data_mem_resp dut (
        .clk                (clk),
        .reset              (reset),
        .data_mem_req_i     (req),
        .data_mem_addr_i    (addr),
        .data_mem_byte_en_i (byte_en),
        .data_mem_wr_i      (wr),
        .data_mem_wr_data_i (wr_data),
        .data_mem_rd_data_o (rd_data),
        .tohost_valid_o     (tohost_valid),
        .tohost_data_o      (tohost_data),
        .err_o              (err),
        .err_addr_o         (err_addr),
        .stat_rd_cnt_o      (stat_rd_cnt),
        .stat_wr_cnt_o      (stat_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a read in the current time step and queue its expected data.
    task automatic rd_now(input logic [1:0] be, input logic [31:0] a, input logic [31:0] exp);
        req     = 1'b1;
        wr      = 1'b0;
        byte_en = be;
        addr    = a;
        wr_data = '0;
        exp_q.push_back(exp);
    endtask

    task automatic rd(input logic [1:0] be, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        rd_now(be, a, exp);
    endtask

    // Write for one cycle; read data must be zero while writing.
    task automatic wrt(input logic [1:0] be, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req     = 1'b1;
        wr      = 1'b1;
        byte_en = be;
        addr    = a;
        wr_data = d;
        #2;
        check("rd_zero_on_write", rd_data, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
            wr  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        wr    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every driven read pops one expectation.
    always @(negedge clk) begin
        #2;
        if (req && !wr) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: read of %h with no expectation", addr);
            end else begin
                check($sformatf("rd@%h", addr), rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        req     = 1'b0;
        wr      = 1'b0;
        byte_en = 2'b11;
        addr    = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd_now(2'b11, CYCLE, 32'd0);
        #1;
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_tohost_valid", {31'b0, tohost_valid}, 32'd0);
        check("rst_tohost_data", tohost_data, 32'd0);
        check("rst_stat_rd", {16'b0, stat_rd_cnt}, 32'd0);
        check("rst_stat_wr", {16'b0, stat_wr_cnt}, 32'd0);

        // Cycle counter after ten edges out of reset.
        idle(9);
        rd(2'b11, CYCLE, 32'd10);
        idle(1);
        #2;
        check("rd_zero_idle", rd_data, 32'h0);

        // Word write then read back.
        wrt(2'b11, 32'h2000, 32'hA5A5_1234);
        rd(2'b11, 32'h2000, 32'hA5A5_1234);
        #1;
        check("no_err_after_word", {31'b0, err}, 32'd0);

        // Byte and half lane merging.
        wrt(2'b11, 32'h2004, 32'h0);
        wrt(2'b00, 32'h2006, 32'h0000_00EF);
        wrt(2'b01, 32'h2004, 32'h0000_BEEF);
        rd(2'b11, 32'h2004, 32'h00EF_BEEF);
        wrt(2'b00, 32'h2007, 32'h1234_56AB);
        rd(2'b11, 32'h2004, 32'hABEF_BEEF);
        wrt(2'b01, 32'h2006, 32'h1111_CAFE);
        rd(2'b11, 32'h2004, 32'hCAFE_BEEF);
        rd(2'b00, 32'h2007, 32'hCAFE_BEEF);
        rd(2'b01, 32'h2006, 32'hCAFE_BEEF);

        // Misaligned word write: no RAM change, first error captured.
        wrt(2'b11, 32'h2002, 32'hDEAD_BEEF);
        idle(1);
        #1;
        check("err_set", {31'b0, err}, 32'd1);
        check("err_addr_first", err_addr, 32'h2002);
        rd(2'b11, 32'h2000, 32'hA5A5_1234);
        rd(2'b11, 32'h9000, 32'h0);
        rd(2'b01, 32'h2005, 32'h0);
        rd(2'b10, 32'h2004, 32'h0);

        // RAM window boundaries.
        wrt(2'b11, 32'h2FFC, 32'h5A5A_5A5A);
        rd(2'b11, 32'h2FFC, 32'h5A5A_5A5A);
        rd(2'b11, 32'h3000, 32'h0);
        rd(2'b11, 32'h1FFC, 32'h0);
        idle(1);
        #1;
        check("err_addr_sticky", err_addr, 32'h2002);

        // Mid-run reset with a write in the reset cycle.
        @(negedge clk);
        reset   = 1'b1;
        req     = 1'b1;
        wr      = 1'b1;
        byte_en = 2'b11;
        addr    = 32'h2000;
        wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        reset = 1'b0;
        rd_now(2'b11, CYCLE, 32'd0);
        #1;
        check("midrst_err", {31'b0, err}, 32'd0);
        check("midrst_err_addr", err_addr, 32'd0);
        rd(2'b11, 32'h2000, 32'hA5A5_1234);
        rd(2'b11, 32'h2004, 32'hCAFE_BEEF);

        // CYCLE writes are ignored without error; TOHOST behaviour.
        wrt(2'b11, CYCLE, 32'h1234);
        idle(1);
        #1;
        check("cycle_wr_no_err", {31'b0, err}, 32'd0);
        wrt(2'b11, TOHOST, 32'h1);
        idle(1);
        #1;
        check("tohost_valid", {31'b0, tohost_valid}, 32'd1);
        check("tohost_data", tohost_data, 32'h1);
        rd(2'b11, TOHOST, 32'h1);
        wrt(2'b00, TOHOST, 32'h55);
        idle(1);
        #1;
        check("tohost_byte_err", {31'b0, err}, 32'd1);
        check("tohost_byte_err_addr", err_addr, TOHOST);
        check("tohost_data_kept", tohost_data, 32'h1);
        wrt(2'b11, TOHOST, 32'h7);
        idle(1);
        #1;
        check("tohost_rewrite_data", tohost_data, 32'h7);
        check("tohost_rewrite_valid", {31'b0, tohost_valid}, 32'd1);

        // Statistics counters.
        do_reset();
        #1;
        check("rst2_tohost_valid", {31'b0, tohost_valid}, 32'd0);
`ifdef YARP_MEM_STATS_EN
        repeat (3) rd(2'b11, 32'h2000, 32'hA5A5_1234);
        rd(2'b11, 32'h9000, 32'h0);
        wrt(2'b11, 32'h2008, 32'h1);
        wrt(2'b11, 32'h2008, 32'h2);
        idle(1);
        #1;
        check("stat_rd_small", {16'b0, stat_rd_cnt}, 32'd3);
        check("stat_wr_small", {16'b0, stat_wr_cnt}, 32'd2);
        repeat (65540) rd(2'b11, 32'h2008, 32'h2);
        idle(1);
        #1;
        check("stat_rd_sat", {16'b0, stat_rd_cnt}, 32'h0000_FFFF);
        check("stat_wr_hold", {16'b0, stat_wr_cnt}, 32'd2);
`else
        repeat (20) rd(2'b11, 32'h2000, 32'hA5A5_1234);
        wrt(2'b11, 32'h2008, 32'h1);
        wrt(2'b11, 32'h2008, 32'h2);
        idle(1);
        #1;
        check("stat_rd_off", {16'b0, stat_rd_cnt}, 32'd0);
        check("stat_wr_off", {16'b0, stat_wr_cnt}, 32'd0);
`endif

        idle(2);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
